instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 151 +++++++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I instruction field sets into 32-bit words and
// queues them in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Illegal requests are accepted but dropped, flagged by a one-cycle err_illegal.
// Optional build macro INSTR_ENC_IMM_CHECK_EN: when defined, in_imm must fit its
// format (sign-extended, aligned where required) or the request is treated as
// illegal; when undefined, in_imm is silently truncated to the format bits.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_illegal,
    output logic [15:0] enc_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    localparam logic [3:0] CLS_ALUREG = 4'd0;
    localparam logic [3:0] CLS_ALUIMM = 4'd1;
    localparam logic [3:0] CLS_BRANCH = 4'd2;
    localparam logic [3:0] CLS_JALR   = 4'd3;
    localparam logic [3:0] CLS_JAL    = 4'd4;
    localparam logic [3:0] CLS_AUIPC  = 4'd5;
    localparam logic [3:0] CLS_LUI    = 4'd6;
    localparam logic [3:0] CLS_LOAD   = 4'd7;
    localparam logic [3:0] CLS_STORE  = 4'd8;
    localparam logic [3:0] CLS_SYSTEM = 4'd9;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [31:0] enc_word;
    logic        op_legal;
    logic        imm_ok;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;

    // Combinational field packing per instruction class
    always_comb begin
        enc_word = '0;
        op_legal = 1'b1;
        case (in_op)
            CLS_ALUREG: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            CLS_ALUIMM: begin
                // Shift-immediates carry funct7 in the upper immediate bits
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            CLS_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                    in_imm[4:1], in_imm[11], 7'b1100011};
            CLS_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            CLS_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                    in_rd, 7'b1101111};
            CLS_AUIPC:  enc_word = {in_imm[31:12], in_rd, 7'b0010111};
            CLS_LUI:    enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            CLS_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            CLS_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                                    7'b0100011};
            CLS_SYSTEM: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1110011};
            default:    op_legal = 1'b0;
        endcase
    end

    // Immediate range check (only in the checking build)
    always_comb begin
        imm_ok = 1'b1;
`ifdef INSTR_ENC_IMM_CHECK_EN
        case (in_op)
            CLS_ALUIMM, CLS_JALR, CLS_LOAD, CLS_SYSTEM, CLS_STORE:
                imm_ok = (in_imm[31:11] == {21{in_imm[11]}});
            CLS_BRANCH:
                imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
            CLS_JAL:
                imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
            CLS_AUIPC, CLS_LUI:
                imm_ok = (in_imm[11:0] == 12'h000);
            default:
                imm_ok = 1'b1;
        endcase
`endif
    end

    assign legal     = op_legal && imm_ok;
    // Gated by rst so the input side looks full while reset is held
    assign in_ready  = !rst && (count != FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

    // FIFO storage; contents need no reset because count masks them
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Illegal-request pulse, high for the cycle after the rejecting accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_illegal <= 1'b0;
        else
            err_illegal <= accept && !legal;
    end

    // Delivered-word counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            enc_count <= 16'h0000;
        else if (pop)
            enc_count <= enc_count + 16'd1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed encodings for instr_encoder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err_illegal;
    logic [15:0] enc_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .err_illegal (err_illegal),
        .enc_count   (enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_fields(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // One-cycle request; the accepting edge falls inside the call
    task automatic push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
    endtask

    task automatic run_one(input string tag, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] exp);
        push(op, rd, rs1, rs2, f3, f7, imm);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check(tag, out_instr, exp);
        pop_one();
        check({tag, "_cnt"}, {16'b0, enc_count}, {16'b0, exp_cnt});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_err", {31'b0, err_illegal}, 32'd0);
        check("rst_enc_count", {16'b0, enc_count}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        // Store held while out_ready is low
        push(4'd8, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("store_hold_valid", {31'b0, out_valid}, 32'd1);
            check("store_hold", out_instr, 32'h0020A223);
            @(negedge clk);
        end
        check("store_cnt_before", {16'b0, enc_count}, 32'd0);
        pop_one();
        check("store_cnt_after", {16'b0, enc_count}, 32'd1);
        check("store_empty", {31'b0, out_valid}, 32'd0);

        // ALUimm addi x1,x0,5 with junk in unused rs2/funct7
        run_one("addi", 4'd1, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5, 32'h00500093);

        // ALUreg then JAL, popped in order
        push(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFF);
        push(4'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        check("order_first", out_instr, 32'h002081B3);
        pop_one();
        check("order_second", out_instr, 32'h008000EF);
        pop_one();
        check("order_empty", {31'b0, out_valid}, 32'd0);
        check("order_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});

        // Remaining formats
        run_one("jalr", 4'd3, 5'd1, 5'd5, 5'd0, 3'd3, 7'd0, 32'hFFFFFFFC, 32'hFFC280E7);
        run_one("load", 4'd7, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'd8, 32'h0081A103);
        run_one("auipc", 4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h12345297);
        run_one("srai", 4'd1, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3, 32'h40315093);
        run_one("branch_neg", 4'd2, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFFFF8, 32'hFE209CE3);
        run_one("ecall", 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000073);

        // Simultaneous push and pop keeps occupancy at one
        push(4'd6, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
        set_fields(4'd6, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00002000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        check("pushpop_valid", {31'b0, out_valid}, 32'd1);
        check("pushpop_head", out_instr, 32'h00002337);
        pop_one();
        check("pushpop_empty", {31'b0, out_valid}, 32'd0);

        // Fill to DEPTH, extra request blocked, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", {31'b0, in_ready}, 32'd1);
            push(4'd6, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1) << 12);
        end
        check("full_ready", {31'b0, in_ready}, 32'd0);
        set_fields(4'd6, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001F000);
        in_valid = 1'b1;
        @(negedge clk);
        check("full_blocked", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("full_pop_ready", {31'b0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", {31'b0, out_valid}, 32'd1);
            check("drain_word", out_instr, ((32'(i + 1)) << 12) | ((32'(i + 1)) << 7) | 32'h37);
            pop_one();
        end
        check("drain_empty", {31'b0, out_valid}, 32'd0);
        check("drain_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});

        // Illegal opcode
        push(4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        check("illegal_err", {31'b0, err_illegal}, 32'd1);
        check("illegal_noenq", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("illegal_err_end", {31'b0, err_illegal}, 32'd0);

        // Misaligned branch immediate
        push(4'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
`ifdef INSTR_ENC_IMM_CHECK_EN
        check("bimm_err", {31'b0, err_illegal}, 32'd1);
        check("bimm_noenq", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("bimm_err_end", {31'b0, err_illegal}, 32'd0);
`else
        check("bimm_noerr", {31'b0, err_illegal}, 32'd0);
        check("bimm_valid", {31'b0, out_valid}, 32'd1);
        check("bimm_word", out_instr, 32'h00000163);
        pop_one();
`endif

        // Mid-operation reset with 3 words queued and a pending error pulse
        push(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
        push(4'd6, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00002000);
        push(4'd6, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00003000);
        push(4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        check("pre_rst_err", {31'b0, err_illegal}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_cnt", {16'b0, enc_count}, 32'd0);
        check("mid_rst_err", {31'b0, err_illegal}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 16'h0000;
        @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        run_one("post_rst_lui", 4'd6, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 32'hABCDE3B7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
